stream_max_min: RTL and testbench

- Parametrised, clocked successor to the combinational two-operand max comparator.
- Consumes a stream of WIDTH-bit samples over a valid/ready handshake and groups them into fixed frames of FRAME_LEN samples.
- For each frame it emits the maximum, the minimum, the index of the maximum and a frame sequence number through a one-deep registered output stage with backpressure.
- Sits between a sample source and a downstream consumer in the lab datapaths.

---
 rtl/stream_max_min_if.sv | 28 ++
 rtl/stream_max_min.sv | 139 +++++++++++++
 tb/tb_stream_max_min.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/stream_max_min_if.sv
// Handshake bundle for stream_max_min: sample input stream and frame result stream.
// The master side is the sample source plus result consumer; the slave side is the block.
interface stream_max_min_if #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 4
);
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [WIDTH-1:0] out_min;
    logic [IDX_W-1:0] out_max_idx;
    logic [7:0]       out_frame_no;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_min, out_max_idx, out_frame_no
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_min, out_max_idx, out_frame_no
    );
endinterface

// File: rtl/stream_max_min.sv
// Frame max/min tracker: groups FRAME_LEN samples, reports max, min, index of the
// first maximum and a wrapping frame number through a one-deep registered output.
module stream_max_min #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 4,
    parameter int SIGNED    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    stream_max_min_if.slave      bus
);
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    // Strict greater-than in the configured number format.
    function automatic logic gt_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic r;
        if (SIGNED != 0) r = ($signed(a) > $signed(b));
        else             r = (a > b);
        return r;
    endfunction

    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_max_q, cur_max_d;
    logic [WIDTH-1:0] cur_min_q, cur_min_d;
    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_max_q, out_max_d;
    logic [WIDTH-1:0] out_min_q, out_min_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [7:0]       frame_no_q, frame_no_d;

    logic             in_ready_s;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] smp_max_s;
    logic [WIDTH-1:0] smp_min_s;
    logic [IDX_W-1:0] smp_idx_s;

    assign in_ready_s = (!out_valid_q || bus.out_ready) && !clr;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign last_s     = (cnt_q == LAST_IDX);

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_max      = out_max_q;
    assign bus.out_min      = out_min_q;
    assign bus.out_max_idx  = out_idx_q;
    assign bus.out_frame_no = frame_no_q;

    // Running max/min/idx including the sample currently on the input; the first
    // sample of a frame seeds all three, ties keep the earlier index.
    always_comb begin
        smp_max_s = cur_max_q;
        smp_min_s = cur_min_q;
        smp_idx_s = cur_idx_q;
        if (cnt_q == {IDX_W{1'b0}}) begin
            smp_max_s = bus.in_data;
            smp_min_s = bus.in_data;
            smp_idx_s = {IDX_W{1'b0}};
        end else begin
            if (gt_f(bus.in_data, cur_max_q)) begin
                smp_max_s = bus.in_data;
                smp_idx_s = cnt_q;
            end else begin
                smp_max_s = cur_max_q;
                smp_idx_s = cur_idx_q;
            end
            if (gt_f(cur_min_q, bus.in_data)) begin
                smp_min_s = bus.in_data;
            end else begin
                smp_min_s = cur_min_q;
            end
        end
    end

    // Next-state: accumulate on accept, load the output stage on frame completion,
    // retire the result on consumer take; clr only drops the partial frame.
    always_comb begin
        cnt_d      = cnt_q;
        cur_max_d  = cur_max_q;
        cur_min_d  = cur_min_q;
        cur_idx_d  = cur_idx_q;
        out_max_d  = out_max_q;
        out_min_d  = out_min_q;
        out_idx_d  = out_idx_q;
        frame_no_d = frame_no_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (clr) begin
            cnt_d = {IDX_W{1'b0}};
        end else if (accept_s) begin
            cur_max_d = smp_max_s;
            cur_min_d = smp_min_s;
            cur_idx_d = smp_idx_s;
            if (last_s) begin
                cnt_d       = {IDX_W{1'b0}};
                out_max_d   = smp_max_s;
                out_min_d   = smp_min_s;
                out_idx_d   = smp_idx_s;
                out_valid_d = 1'b1;
                frame_no_d  = frame_no_q + 8'd1;
            end else begin
                cnt_d = cnt_q + IDX_W'(1'b1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= {IDX_W{1'b0}};
            cur_max_q   <= {WIDTH{1'b0}};
            cur_min_q   <= {WIDTH{1'b0}};
            cur_idx_q   <= {IDX_W{1'b0}};
            out_valid_q <= 1'b0;
            out_max_q   <= {WIDTH{1'b0}};
            out_min_q   <= {WIDTH{1'b0}};
            out_idx_q   <= {IDX_W{1'b0}};
            frame_no_q  <= 8'd0;
        end else begin
            cnt_q       <= cnt_d;
            cur_max_q   <= cur_max_d;
            cur_min_q   <= cur_min_d;
            cur_idx_q   <= cur_idx_d;
            out_valid_q <= out_valid_d;
            out_max_q   <= out_max_d;
            out_min_q   <= out_min_d;
            out_idx_q   <= out_idx_d;
            frame_no_q  <= frame_no_d;
        end
    end
endmodule

// File: tb/tb_stream_max_min.sv
// Directed bench for stream_max_min: an unsigned and a signed FRAME_LEN=4 instance
// share one stimulus stream, a FRAME_LEN=2 instance takes the exhaustive pair sweep.
module tb_stream_max_min;
    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    int   total = 0;
    int   bad   = 0;
    int   exp_fno = 0;

    always #5 clk = ~clk;

    stream_max_min_if #(.WIDTH(4), .FRAME_LEN(4)) if0 ();
    stream_max_min_if #(.WIDTH(4), .FRAME_LEN(4)) if1 ();
    stream_max_min_if #(.WIDTH(4), .FRAME_LEN(2)) if2 ();

    assign if1.in_valid  = if0.in_valid;
    assign if1.in_data   = if0.in_data;
    assign if1.out_ready = if0.out_ready;

    stream_max_min #(.WIDTH(4), .FRAME_LEN(4), .SIGNED(0)) u_uns (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if0));
    stream_max_min #(.WIDTH(4), .FRAME_LEN(4), .SIGNED(1)) u_sgn (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1));
    stream_max_min #(.WIDTH(4), .FRAME_LEN(2), .SIGNED(0)) u_pair (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if2));

    typedef struct {
        logic [0:3][3:0] s;
        logic [3:0] umax, umin;
        logic [1:0] uidx;
        logic [3:0] smax, smin;
        logic [1:0] sidx;
    } vec_t;

    vec_t tv[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        if0.in_valid = 1'b1;
        if0.in_data  = d;
        step();
    endtask

    task automatic chk_u0(input string nm, input logic v, input logic [3:0] mx,
                          input logic [3:0] mn, input logic [1:0] ix);
        chk({nm, ".valid"}, 32'(if0.out_valid), 32'(v));
        chk({nm, ".max"},   32'(if0.out_max), 32'(mx));
        chk({nm, ".min"},   32'(if0.out_min), 32'(mn));
        chk({nm, ".idx"},   32'(if0.out_max_idx), 32'(ix));
        chk({nm, ".fno"},   32'(if0.out_frame_no), 32'(exp_fno % 256));
    endtask

    initial begin
        tv[0] = '{{4'h3, 4'h9, 4'h9, 4'h2}, 4'h9, 4'h2, 2'd1, 4'h3, 4'h9, 2'd0};
        tv[1] = '{{4'hF, 4'h7, 4'h8, 4'h0}, 4'hF, 4'h0, 2'd0, 4'h7, 4'h8, 2'd1};
        tv[2] = '{{4'h5, 4'h5, 4'h5, 4'h5}, 4'h5, 4'h5, 2'd0, 4'h5, 4'h5, 2'd0};
        tv[3] = '{{4'h0, 4'h1, 4'hE, 4'h2}, 4'hE, 4'h0, 2'd2, 4'h2, 4'hE, 2'd3};
        tv[4] = '{{4'h8, 4'h7, 4'h7, 4'hF}, 4'hF, 4'h7, 2'd3, 4'h7, 4'h8, 2'd1};

        rst_n = 1'b0; clr = 1'b0;
        if0.in_valid = 1'b0; if0.in_data = 4'h0; if0.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.in_data = 4'h0; if2.out_ready = 1'b1;
        step(); step();

        // reset state
        chk_u0("rst", 1'b0, 4'h0, 4'h0, 2'd0);
        chk("rst.in_ready", 32'(if0.in_ready), 32'd1);
        chk("rst.pair_valid", 32'(if2.out_valid), 32'd0);
        chk("rst.pair_fno", 32'(if2.out_frame_no), 32'd0);
        rst_n = 1'b1;

        // table of full frames, back-to-back with out_ready=1
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) push(tv[i].s[j]);
            if0.in_valid = 1'b0;
            exp_fno++;
            chk_u0($sformatf("tv%0d", i), 1'b1, tv[i].umax, tv[i].umin, tv[i].uidx);
            chk($sformatf("tv%0d.smax", i), 32'(if1.out_max), 32'(tv[i].smax));
            chk($sformatf("tv%0d.smin", i), 32'(if1.out_min), 32'(tv[i].smin));
            chk($sformatf("tv%0d.sidx", i), 32'(if1.out_max_idx), 32'(tv[i].sidx));
        end
        step();
        chk("drain.valid", 32'(if0.out_valid), 32'd0);

        // backpressure: result held, input stalled, then released
        if0.out_ready = 1'b0;
        push(4'd1); push(4'd2); push(4'd3); push(4'd4);
        exp_fno++;
        if0.in_valid = 1'b1; if0.in_data = 4'd5;
        #1;
        chk("bp.in_ready", 32'(if0.in_ready), 32'd0);
        for (int c = 0; c < 10; c++) begin
            chk_u0("bp.hold", 1'b1, 4'd4, 4'd1, 2'd3);
            chk("bp.in_ready_hold", 32'(if0.in_ready), 32'd0);
            step();
        end
        if0.out_ready = 1'b1;
        #1;
        chk("bp.in_ready_rel", 32'(if0.in_ready), 32'd1);
        step();
        chk("bp.valid_drop", 32'(if0.out_valid), 32'd0);
        push(4'd1); push(4'd1); push(4'd1);
        if0.in_valid = 1'b0;
        exp_fno++;
        chk_u0("bp.idx0", 1'b1, 4'd5, 4'd1, 2'd0);

        // clr discards the partial frame and the sample offered with it
        push(4'd15); push(4'd14);
        clr = 1'b1; if0.in_valid = 1'b1; if0.in_data = 4'd13;
        #1;
        chk("clr.in_ready", 32'(if0.in_ready), 32'd0);
        step();
        clr = 1'b0;
        chk("clr.fno_kept", 32'(if0.out_frame_no), 32'(exp_fno % 256));
        push(4'd1); push(4'd2); push(4'd3); push(4'd4);
        if0.in_valid = 1'b0;
        exp_fno++;
        chk_u0("clr", 1'b1, 4'd4, 4'd1, 2'd3);

        // reset with a pending result, then reset with a partial frame
        step();
        if0.out_ready = 1'b0;
        push(4'd1); push(4'd2); push(4'd3); push(4'd4);
        if0.in_valid = 1'b0;
        chk("rst6.pending", 32'(if0.out_valid), 32'd1);
        rst_n = 1'b0; if0.in_valid = 1'b1; if0.in_data = 4'd15;
        step();
        rst_n = 1'b1; if0.in_valid = 1'b0;
        #1;
        exp_fno = 0;
        chk_u0("rst6", 1'b0, 4'd0, 4'd0, 2'd0);
        chk("rst6.in_ready", 32'(if0.in_ready), 32'd1);
        if0.out_ready = 1'b1;
        push(4'd15); push(4'd0); push(4'd15);
        if0.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        push(4'd6); push(4'd6); push(4'd6); push(4'd6);
        if0.in_valid = 1'b0;
        exp_fno = 1;
        chk_u0("rst6.frame", 1'b1, 4'd6, 4'd6, 2'd0);

        // exhaustive pairs on the FRAME_LEN=2 instance, frame counter wraps
        for (int k = 0; k < 256; k++) begin
            logic [3:0] a, b, emx, emn;
            logic ei;
            a = 4'(k / 16);
            b = 4'(k % 16);
            emx = (b > a) ? b : a;
            emn = (b < a) ? b : a;
            ei  = (b > a);
            if2.in_valid = 1'b1; if2.in_data = a; step();
            if2.in_data = b; step();
            chk($sformatf("pair%0d.valid", k), 32'(if2.out_valid), 32'd1);
            chk($sformatf("pair%0d.max", k), 32'(if2.out_max), 32'(emx));
            chk($sformatf("pair%0d.min", k), 32'(if2.out_min), 32'(emn));
            chk($sformatf("pair%0d.idx", k), 32'(if2.out_max_idx), 32'(ei));
            chk($sformatf("pair%0d.fno", k), 32'(if2.out_frame_no), 32'((k + 1) % 256));
        end
        if2.in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
